// File: rtl/sr_pkg.sv
// Shared definitions for the shift/rotate result stage: shift/rotate mode
// encodings, the buffered entry layout and a small mode-legality helper.
package sr_pkg;

    localparam int SR_DATA_W = 8;

    // One-hot mode encodings carried in b_in[7:4]
    localparam logic [3:0] MODE_SHL = 4'b0001;
    localparam logic [3:0] MODE_SHR = 4'b0010;
    localparam logic [3:0] MODE_ROR = 4'b0100;
    localparam logic [3:0] MODE_ROL = 4'b1000;

    // One buffered result together with its flags
    typedef struct packed {
        logic [SR_DATA_W-1:0] data;
        logic                 zero;
        logic                 carry;
        logic                 err;
    } sr_entry_t;

    // True when the mode field names one of the four supported operations
    function automatic logic mode_is_legal(input logic [3:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR) ||
               (mode == MODE_ROR) || (mode == MODE_ROL);
    endfunction

endpackage

// File: rtl/sr_flag_calc.sv
// Combinational flag generation for one shift/rotate result: zero, carry
// (last bit shifted or rotated out) and illegal-mode error. An illegal mode
// forces the stored data to zero so garbage never reaches writeback.
module sr_flag_calc
    import sr_pkg::*;
(
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic [7:0] y_in,
    output sr_entry_t  entry_out
);

    logic [3:0] w_mode;
    logic [3:0] w_n;
    logic       w_n_in_range;
    logic [2:0] w_shl_idx;
    logic [2:0] w_shr_idx;
    logic       w_rot_nonzero;

    assign w_mode = b_in[7:4];
    assign w_n    = b_in[3:0];

    // Shift amounts 1..8 move at least one bit out; 0 and 9..15 give no carry
    assign w_n_in_range = (w_n >= 4'd1) && (w_n <= 4'd8);

    // For n in 1..8: (8 - n) mod 8 and (n - 1) mod 8 select the last bit out
    assign w_shl_idx = 3'd0 - w_n[2:0];
    assign w_shr_idx = w_n[2:0] - 3'd1;

    // Rotations by a multiple of 8 leave the operand unchanged and move nothing out
    assign w_rot_nonzero = (w_n[2:0] != 3'd0);

    // Select carry per mode and force data to zero on an illegal mode
    always_comb begin
        entry_out       = '0;
        entry_out.data  = y_in;
        entry_out.zero  = (y_in == 8'd0);
        entry_out.carry = 1'b0;
        entry_out.err   = 1'b0;
        if (!mode_is_legal(w_mode)) begin
            entry_out.err  = 1'b1;
            entry_out.data = 8'd0;
        end else begin
            case (w_mode)
                MODE_SHL: entry_out.carry = w_n_in_range ? a_in[w_shl_idx] : 1'b0;
                MODE_SHR: entry_out.carry = w_n_in_range ? a_in[w_shr_idx] : 1'b0;
                MODE_ROR: entry_out.carry = w_rot_nonzero ? y_in[7] : 1'b0;
                MODE_ROL: entry_out.carry = w_rot_nonzero ? y_in[0] : 1'b0;
                default:  entry_out.carry = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/sr_result_stage.sv
// Result stage behind the shift/rotate unit: flags each result as it is
// captured, buffers it in a DEPTH-entry FIFO and hands it to writeback.
// Optional macro SR_STATS_EN adds saturating pop and error-push counters.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on registered occupancy (never on out_ready);
// out_valid is high whenever the FIFO is non-empty, and out_* hold the head
// entry until it is popped. When out_valid is low out_* are stale.
module sr_result_stage
    import sr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] y_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              out_carry,
    output logic              out_err
`ifdef SR_STATS_EN
    ,
    output logic [15:0]       ops_cnt_out,
    output logic [7:0]        err_cnt_out
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    sr_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    sr_entry_t w_entry;
    logic      w_push;
    logic      w_pop;

    sr_flag_calc u_flag_calc (
        .a_in      (a_in),
        .b_in      (b_in),
        .y_in      (y_in),
        .entry_out (w_entry)
    );

    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_data  = r_mem[r_rd_ptr].data;
    assign out_zero  = r_mem[r_rd_ptr].zero;
    assign out_carry = r_mem[r_rd_ptr].carry;
    assign out_err   = r_mem[r_rd_ptr].err;

    // FIFO storage, pointers and occupancy; reset beats flush beats push/pop
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= PTR_W'(r_wr_ptr + 1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SR_STATS_EN
    logic [15:0] r_ops_cnt;
    logic [7:0]  r_err_cnt;

    // Saturating usage counters; only reset clears them, flush leaves them alone
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ops_cnt <= '0;
            r_err_cnt <= '0;
        end else if (!flush_in) begin
            if (w_pop && (r_ops_cnt != 16'hFFFF)) begin
                r_ops_cnt <= r_ops_cnt + 16'd1;
            end
            if (w_push && w_entry.err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign ops_cnt_out = r_ops_cnt;
    assign err_cnt_out = r_err_cnt;
`endif

endmodule
